// File: rtl/imm_gen_pipe.sv
// RV32/RV64 immediate generator for decode: combinational format decode feeding a
// 2-entry (main + skid) valid/ready buffer with synchronous flush.
module imm_gen_pipe #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);

    localparam logic [2:0] FmtI    = 3'b000;
    localparam logic [2:0] FmtS    = 3'b001;
    localparam logic [2:0] FmtB    = 3'b010;
    localparam logic [2:0] FmtU    = 3'b011;
    localparam logic [2:0] FmtJ    = 3'b100;
    localparam logic [2:0] FmtZ    = 3'b101;
    localparam logic [2:0] FmtNone = 3'b111;

    localparam int unsigned EntryW = XLEN + 4;

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    state_e state_q, state_d;

    logic [31:0]       imm32;
    logic [XLEN-1:0]   dec_imm;
    logic [2:0]        dec_fmt;
    logic              dec_ill;
    logic [EntryW-1:0] dec_entry;
    logic [EntryW-1:0] main_q, skid_q;
    logic              main_ld, main_from_skid, skid_ld;
    logic              acc, pop;

    always_comb begin
        imm32   = '0;
        dec_fmt = FmtNone;
        dec_ill = 1'b0;
        unique case (in_instr[6:0])
            7'b0000011, 7'b0010011, 7'b1100111: begin
                imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
                dec_fmt = FmtI;
            end
            7'b0100011: begin
                imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
                dec_fmt = FmtS;
            end
            7'b1100011: begin
                imm32   = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
                dec_fmt = FmtB;
            end
            7'b0110111, 7'b0010111: begin
                imm32   = {in_instr[31:12], 12'b0};
                dec_fmt = FmtU;
            end
            7'b1101111: begin
                imm32   = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21],
                           1'b0};
                dec_fmt = FmtJ;
            end
            7'b1110011: begin
                if (in_instr[14]) begin
                    imm32   = {27'b0, in_instr[19:15]};
                    dec_fmt = FmtZ;
                end else begin
                    imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
                    dec_fmt = FmtI;
                end
            end
            default: begin
                dec_ill = 1'b1;
            end
        endcase
        // imm32 already carries the correct bit 31, so widening is a plain sign extension.
        dec_imm = XLEN'($signed(imm32));
    end

    assign dec_entry = {dec_ill, dec_fmt, dec_imm};

    // Ready is a function of registered state only; rst just masks it.
    assign in_ready  = (state_q != StTwo) && !rst;
    assign out_valid = (state_q != StEmpty);
    assign acc       = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        state_d        = state_q;
        main_ld        = 1'b0;
        main_from_skid = 1'b0;
        skid_ld        = 1'b0;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (acc) begin
                        state_d = StOne;
                        main_ld = 1'b1;
                    end
                end
                StOne: begin
                    if (acc && !pop) begin
                        state_d = StTwo;
                        skid_ld = 1'b1;
                    end else if (acc && pop) begin
                        main_ld = 1'b1;
                    end else if (pop) begin
                        state_d = StEmpty;
                    end
                end
                StTwo: begin
                    if (pop) begin
                        state_d        = StOne;
                        main_ld        = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StEmpty;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            if (main_ld) begin
                main_q <= main_from_skid ? skid_q : dec_entry;
            end
            if (skid_ld) begin
                skid_q <= dec_entry;
            end
        end
    end

    assign out_imm     = main_q[XLEN-1:0];
    assign out_fmt     = main_q[XLEN+2:XLEN];
    assign out_illegal = main_q[XLEN+3];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed and scoreboarded checks of imm_gen_pipe, with XLEN=32 and XLEN=64 instances
// driven from the same stimulus.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_instr;

    logic        rdy32, v32, ill32, rdy64, v64, ill64;
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [2:0]  fmt32, fmt64;

    int tests = 0;
    int fails = 0;

    imm_gen_pipe #(.XLEN(32)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
        .in_instr(in_instr), .out_valid(v32), .out_ready(out_ready), .out_imm(imm32),
        .out_fmt(fmt32), .out_illegal(ill32)
    );

    imm_gen_pipe #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
        .in_instr(in_instr), .out_valid(v64), .out_ready(out_ready), .out_imm(imm64),
        .out_fmt(fmt64), .out_illegal(ill64)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Reference decode built from arithmetic shifts rather than bit concatenation.
    task automatic ref_decode(input logic [31:0] i, output logic [63:0] imm,
                              output logic [2:0] fmt, output logic ill);
        logic signed [31:0] si;
        logic [31:0]        hi, r;
        si  = i;
        r   = '0;
        fmt = 3'b111;
        ill = 1'b0;
        case (i[6:0])
            7'b0000011, 7'b0010011, 7'b1100111: begin r = si >>> 20; fmt = 3'b000; end
            7'b0100011: begin
                hi = si >>> 25;
                r = (hi << 5) | 32'(i[11:7]);
                fmt = 3'b001;
            end
            7'b1100011: begin
                hi = si >>> 31;
                r = (hi << 12) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
                fmt = 3'b010;
            end
            7'b0110111, 7'b0010111: begin r = i & 32'hFFFF_F000; fmt = 3'b011; end
            7'b1101111: begin
                hi = si >>> 31;
                r = (hi << 20) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11)
                    | (32'(i[30:21]) << 1);
                fmt = 3'b100;
            end
            7'b1110011: begin
                if (i[14]) begin r = 32'(i[19:15]); fmt = 3'b101; end
                else begin r = si >>> 20; fmt = 3'b000; end
            end
            default: ill = 1'b1;
        endcase
        imm = {{32{r[31]}}, r};
    endtask

    task automatic test_reset;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0;
        step;
        step;
        tests++;
        if (rdy32 !== 1'b0 || rdy64 !== 1'b0)
            $display("FAIL reset_ready: got %b/%b want 0", rdy32, rdy64);
        tests++;
        if (v32 !== 1'b0 || imm32 !== 32'h0 || fmt32 !== 3'b000 || ill32 !== 1'b0
            || v64 !== 1'b0 || imm64 !== 64'h0)
            $display("FAIL reset_outputs: got v=%b imm=%h fmt=%b ill=%b imm64=%h want zeros",
                     v32, imm32, fmt32, ill32, imm64);
        rst = 1'b0;
        #1;
        tests++;
        if (rdy32 !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", rdy32);
        fails = fails; // keep counts visible
    endtask

    task automatic test_decode(input string name, input logic [31:0] instr,
                               input logic [63:0] exp_imm, input logic [2:0] exp_fmt,
                               input logic exp_ill);
        logic [31:0] exp32;
        exp32 = exp_imm[31:0];
        in_valid = 1'b1; in_instr = instr; out_ready = 1'b1;
        tests++;
        if (rdy32 !== 1'b1) begin
            fails++; $display("FAIL %s_ready: got %b want 1", name, rdy32);
        end
        step;
        in_valid = 1'b0;
        tests++;
        if (v32 !== 1'b1 || imm32 !== exp32 || fmt32 !== exp_fmt || ill32 !== exp_ill) begin
            fails++;
            $display("FAIL %s_x32: got v=%b imm=%h fmt=%b ill=%b want v=1 imm=%h fmt=%b ill=%b",
                     name, v32, imm32, fmt32, ill32, exp32, exp_fmt, exp_ill);
        end
        tests++;
        if (v64 !== 1'b1 || imm64 !== exp_imm || fmt64 !== exp_fmt || ill64 !== exp_ill) begin
            fails++;
            $display("FAIL %s_x64: got v=%b imm=%h fmt=%b ill=%b want v=1 imm=%h fmt=%b ill=%b",
                     name, v64, imm64, fmt64, ill64, exp_imm, exp_fmt, exp_ill);
        end
        step;
        tests++;
        if (v32 !== 1'b0) begin
            fails++; $display("FAIL %s_drain: got out_valid=%b want 0", name, v32);
        end
    endtask

    task automatic test_back_to_back;
        logic stable_ok;
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h0010_0093;
        step;
        in_instr = 32'h0020_0093;
        tests++;
        if (rdy32 !== 1'b1 || v32 !== 1'b1 || imm32 !== 32'd1) begin
            fails++; $display("FAIL b2b_one: got rdy=%b v=%b imm=%h want 1 1 1", rdy32, v32, imm32);
        end
        step;
        in_instr = 32'h0030_0093;
        tests++;
        if (rdy32 !== 1'b0) begin
            fails++; $display("FAIL b2b_full_ready: got %b want 0", rdy32);
        end
        stable_ok = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step;
            if (v32 !== 1'b1 || imm32 !== 32'd1 || fmt32 !== 3'b000 || rdy32 !== 1'b0)
                stable_ok = 1'b0;
        end
        tests++;
        if (!stable_ok) begin
            fails++; $display("FAIL b2b_stall_stable: got imm=%h rdy=%b want imm=1 rdy=0", imm32, rdy32);
        end
        out_ready = 1'b1;
        step;
        tests++;
        if (v32 !== 1'b1 || imm32 !== 32'd2 || rdy32 !== 1'b1) begin
            fails++; $display("FAIL b2b_second: got v=%b imm=%h rdy=%b want 1 2 1", v32, imm32, rdy32);
        end
        step;
        in_valid = 1'b0;
        tests++;
        if (v32 !== 1'b1 || imm32 !== 32'd3) begin
            fails++; $display("FAIL b2b_third: got v=%b imm=%h want 1 3", v32, imm32);
        end
        step;
        tests++;
        if (v32 !== 1'b0) begin
            fails++; $display("FAIL b2b_empty: got out_valid=%b want 0", v32);
        end
    endtask

    task automatic test_flush;
        logic leak;
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h0010_0093;
        step;
        in_instr = 32'h0020_0093;
        step;
        tests++;
        if (rdy32 !== 1'b0 || v32 !== 1'b1) begin
            fails++; $display("FAIL flush_setup: got rdy=%b v=%b want 0 1", rdy32, v32);
        end
        flush = 1'b1; in_instr = 32'h0070_0093;
        step;
        flush = 1'b0; in_valid = 1'b0;
        tests++;
        if (v32 !== 1'b0 || rdy32 !== 1'b1 || v64 !== 1'b0) begin
            fails++; $display("FAIL flush_empty: got v=%b rdy=%b want 0 1", v32, rdy32);
        end
        out_ready = 1'b1;
        leak = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step;
            if (v32 !== 1'b0) leak = 1'b1;
        end
        tests++;
        if (leak) begin
            fails++; $display("FAIL flush_dropped: got out_valid=1 imm=%h want none", imm32);
        end
    endtask

    task automatic test_reset_midstream;
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'hFFF0_0093;
        step;
        in_valid = 1'b0;
        tests++;
        if (v32 !== 1'b1 || imm32 !== 32'hFFFF_FFFF) begin
            fails++; $display("FAIL rstmid_setup: got v=%b imm=%h want 1 ffffffff", v32, imm32);
        end
        rst = 1'b1;
        #1;
        tests++;
        if (rdy32 !== 1'b0) begin
            fails++; $display("FAIL rstmid_ready_low: got %b want 0", rdy32);
        end
        step;
        rst = 1'b0;
        #1;
        tests++;
        if (v32 !== 1'b0 || imm32 !== 32'h0 || fmt32 !== 3'b000 || ill32 !== 1'b0
            || imm64 !== 64'h0 || rdy32 !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_values: got v=%b imm=%h fmt=%b ill=%b rdy=%b want 0 0 000 0 1",
                     v32, imm32, fmt32, ill32, rdy32);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_random;
        logic [63:0] q_imm[$];
        logic [2:0]  q_fmt[$];
        logic        q_ill[$];
        logic [6:0]  opcs[10];
        logic [31:0] instr;
        logic [63:0] e_imm;
        logic [2:0]  e_fmt;
        logic        e_ill;
        opcs = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b0100011, 7'b1100011,
                 7'b0110111, 7'b0010111, 7'b1101111, 7'b1110011, 7'b0101011};
        for (int c = 0; c < 400; c++) begin
            in_valid  = (c < 40) ? 1'b1 : ($urandom_range(0, 3) != 0);
            out_ready = (c < 40) ? 1'b1 : ($urandom_range(0, 3) != 0);
            instr = $urandom;
            instr[6:0] = opcs[$urandom_range(0, 9)];
            in_instr = instr;
            #1;
            tests++;
            if (rdy32 !== (q_imm.size() < 2) || v32 !== (q_imm.size() != 0)) begin
                fails++;
                $display("FAIL rand_occupancy c=%0d: got rdy=%b v=%b want entries=%0d",
                         c, rdy32, v32, q_imm.size());
            end
            if (v32 && out_ready) begin
                tests++;
                if (q_imm.size() == 0) begin
                    fails++; $display("FAIL rand_pop c=%0d: got unexpected entry imm=%h", c, imm32);
                end else if (imm32 !== q_imm[0][31:0] || imm64 !== q_imm[0] || fmt32 !== q_fmt[0]
                             || fmt64 !== q_fmt[0] || ill32 !== q_ill[0] || ill64 !== q_ill[0]) begin
                    fails++;
                    $display("FAIL rand_pop c=%0d: got imm64=%h fmt=%b ill=%b want %h %b %b",
                             c, imm64, fmt64, ill64, q_imm[0], q_fmt[0], q_ill[0]);
                end
                if (q_imm.size() != 0) begin
                    void'(q_imm.pop_front()); void'(q_fmt.pop_front()); void'(q_ill.pop_front());
                end
            end
            if (in_valid && rdy32) begin
                ref_decode(instr, e_imm, e_fmt, e_ill);
                q_imm.push_back(e_imm); q_fmt.push_back(e_fmt); q_ill.push_back(e_ill);
            end
            step;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 4 && q_imm.size() != 0; c++) begin
            tests++;
            if (v32 !== 1'b1 || imm64 !== q_imm[0] || fmt64 !== q_fmt[0]) begin
                fails++;
                $display("FAIL rand_drain: got v=%b imm64=%h fmt=%b want 1 %h %b",
                         v32, imm64, fmt64, q_imm[0], q_fmt[0]);
            end
            void'(q_imm.pop_front()); void'(q_fmt.pop_front()); void'(q_ill.pop_front());
            step;
        end
        tests++;
        if (q_imm.size() != 0 || v32 !== 1'b0) begin
            fails++; $display("FAIL rand_final: got left=%0d v=%b want 0 0", q_imm.size(), v32);
        end
    endtask

    initial begin
        test_reset;
        if (rdy32 !== 1'b1 || v32 !== 1'b0 || imm32 !== 32'h0 || rdy64 !== 1'b1) fails++;
        test_decode("addi",   32'hFFF0_0093, 64'hFFFF_FFFF_FFFF_FFFF, 3'b000, 1'b0);
        test_decode("sw",     32'h0020_A423, 64'h0000_0000_0000_0008, 3'b001, 1'b0);
        test_decode("beq",    32'hFE00_0EE3, 64'hFFFF_FFFF_FFFF_FFFC, 3'b010, 1'b0);
        test_decode("lui",    32'h1234_50B7, 64'h0000_0000_1234_5000, 3'b011, 1'b0);
        test_decode("jal",    32'h0010_006F, 64'h0000_0000_0000_0800, 3'b100, 1'b0);
        test_decode("csrrwi", 32'h0002_D073, 64'h0000_0000_0000_0005, 3'b101, 1'b0);
        test_decode("illegal", 32'h0000_007F, 64'h0, 3'b111, 1'b1);
        test_decode("lui64",  32'h8000_00B7, 64'hFFFF_FFFF_8000_0000, 3'b011, 1'b0);
        test_back_to_back;
        test_flush;
        test_reset_midstream;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
